// File: rtl/mi_ram_arb_if.sv
// Bus bundle for the RAM-port arbiter.
// It groups the Cpu data port, the external master port, the RAM macro port,
// the exec-enable pair, the conflict counter and two debug taps.
//
// Handshake rules:
// - Cpu: a request is any non-zero ACpuWrEn/ACpuRdEn.
//   The Cpu holds the request stable while AExecEnO=0.
//   Read data arrives on ACpuMiso one enabled cycle after the grant.
// - Ext: AExtReq is a level. The master holds Addr/Mosi/WrEn/RdEn until it
//   samples AExtAck=1. AExtAck is a single enabled-cycle pulse, and AExtMiso
//   is valid only while AExtAck=1.
// - Mem: the RAM samples AMem* on enabled edges and returns AMemMiso one
//   enabled cycle after a non-zero AMemRdEn.
interface mi_ram_arb_if #(
    parameter int CCntW = 16
);
    logic              AExecEnI;
    logic              AExecEnO;

    logic [28:0]       ACpuAddr;
    logic [63:0]       ACpuMosi;
    logic [7:0]        ACpuWrEn;
    logic [7:0]        ACpuRdEn;
    logic [63:0]       ACpuMiso;

    logic              AExtReq;
    logic [28:0]       AExtAddr;
    logic [63:0]       AExtMosi;
    logic [7:0]        AExtWrEn;
    logic [7:0]        AExtRdEn;
    logic              AExtAck;
    logic [63:0]       AExtMiso;

    logic [28:0]       AMemAddr;
    logic [63:0]       AMemMosi;
    logic [7:0]        AMemWrEn;
    logic [7:0]        AMemRdEn;
    logic [63:0]       AMemMiso;

    logic [CCntW-1:0]  AConflictCnt;

    // Debug taps: round-robin priority and read-owner tag.
    logic              ADbgPrio;
    logic [1:0]        ADbgRdOwner;

    // Arbiter side.
    modport slave (
        input  AExecEnI,
        output AExecEnO,
        input  ACpuAddr, ACpuMosi, ACpuWrEn, ACpuRdEn,
        output ACpuMiso,
        input  AExtReq, AExtAddr, AExtMosi, AExtWrEn, AExtRdEn,
        output AExtAck, AExtMiso,
        output AMemAddr, AMemMosi, AMemWrEn, AMemRdEn,
        input  AMemMiso,
        output AConflictCnt,
        output ADbgPrio, ADbgRdOwner
    );

    // Environment side: requesters plus the RAM macro.
    modport master (
        output AExecEnI,
        input  AExecEnO,
        output ACpuAddr, ACpuMosi, ACpuWrEn, ACpuRdEn,
        input  ACpuMiso,
        output AExtReq, AExtAddr, AExtMosi, AExtWrEn, AExtRdEn,
        input  AExtAck, AExtMiso,
        input  AMemAddr, AMemMosi, AMemWrEn, AMemRdEn,
        output AMemMiso,
        input  AConflictCnt,
        input  ADbgPrio, ADbgRdOwner
    );
endinterface

// File: rtl/mi_ram_arb.sv
// Two-master arbiter for the single 64-bit RAM port.
// The Cpu data port and an external master (debug/DMA/loader) share one RAM
// macro with 1-cycle read latency. Arbitration is decided combinationally
// every cycle, and read data is steered back using a registered owner tag.
// When the Cpu loses arbitration it is stalled through exec-enable.
// All registers advance only on AClkH edges where AClkHEn=1; the RAM sees the
// same enable, so the address/data mux is not gated.
module mi_ram_arb #(
    parameter bit CCpuFirst = 1'b1,
    parameter int CCntW     = 16
) (
    input  logic          AClkH,
    input  logic          AResetH,
    input  logic          AClkHEn,
    mi_ram_arb_if.slave   ABus
);

    typedef enum logic [1:0] {
        OwnNone = 2'd0,
        OwnCpu  = 2'd1,
        OwnExt  = 2'd2
    } owner_t;

    // Registered state
    logic             fPrio;        // 1: Cpu wins the next conflict
    owner_t           fRdOwner;     // who receives AMemMiso this cycle
    logic             fExtAck;      // Ext completion pulse
    logic [CCntW-1:0] fConflictCnt;

    // Combinational decode
    logic   cpuReq;
    logic   extElig;
    logic   cpuGrant;
    logic   extGrant;
    owner_t rdOwnerNext;

    // Request qualification.
    // Ext is masked during its own ack cycle, so a held request is not
    // mistaken for a second access.
    always_comb begin
        cpuReq  = (|ABus.ACpuWrEn) | (|ABus.ACpuRdEn);
        extElig = ABus.AExtReq & ~fExtAck;
    end

    // Grant.
    // A lone requester always wins; on a conflict fPrio picks the winner.
    always_comb begin
        cpuGrant = 1'b0;
        extGrant = 1'b0;
        if (cpuReq && extElig) begin
            cpuGrant = fPrio;
            extGrant = ~fPrio;
        end else if (cpuReq) begin
            cpuGrant = 1'b1;
        end else if (extElig) begin
            extGrant = 1'b1;
        end
    end

    // RAM port mux: forward the granted side as-is; drive zeros when idle.
    always_comb begin
        ABus.AMemAddr = '0;
        ABus.AMemMosi = '0;
        ABus.AMemWrEn = '0;
        ABus.AMemRdEn = '0;
        if (cpuGrant) begin
            ABus.AMemAddr = ABus.ACpuAddr;
            ABus.AMemMosi = ABus.ACpuMosi;
            ABus.AMemWrEn = ABus.ACpuWrEn;
            ABus.AMemRdEn = ABus.ACpuRdEn;
        end else if (extGrant) begin
            ABus.AMemAddr = ABus.AExtAddr;
            ABus.AMemMosi = ABus.AExtMosi;
            ABus.AMemWrEn = ABus.AExtWrEn;
            ABus.AMemRdEn = ABus.AExtRdEn;
        end
    end

    // Stall the Cpu only while it has a request that was not granted.
    always_comb begin
        ABus.AExecEnO = ABus.AExecEnI & ~(cpuReq & ~cpuGrant);
    end

    // Tag the next RAM read with the side that issued it.
    always_comb begin
        rdOwnerNext = OwnNone;
        if (cpuGrant && (|ABus.ACpuRdEn)) begin
            rdOwnerNext = OwnCpu;
        end else if (extGrant && (|ABus.AExtRdEn)) begin
            rdOwnerNext = OwnExt;
        end
    end

    // Round-robin priority.
    // Only a real conflict moves the priority, and it moves to the loser.
    always_ff @(posedge AClkH or posedge AResetH) begin
        if (AResetH) begin
            fPrio <= CCpuFirst;
        end else if (AClkHEn && cpuReq && extElig) begin
            fPrio <= ~cpuGrant;
        end
    end

    // Read-owner tag and Ext ack.
    // A reset drops any in-flight Ext access without an ack.
    always_ff @(posedge AClkH or posedge AResetH) begin
        if (AResetH) begin
            fRdOwner <= OwnNone;
            fExtAck  <= 1'b0;
        end else if (AClkHEn) begin
            fRdOwner <= rdOwnerNext;
            fExtAck  <= extGrant;
        end
    end

    // Saturating count of enabled cycles in which both sides were competing.
    always_ff @(posedge AClkH or posedge AResetH) begin
        if (AResetH) begin
            fConflictCnt <= '0;
        end else if (AClkHEn && cpuReq && extElig && !(&fConflictCnt)) begin
            fConflictCnt <= fConflictCnt + CCntW'(1);
        end
    end

    // Read-data return: each side sees RAM data only when it owns it.
    always_comb begin
        ABus.ACpuMiso = '0;
        ABus.AExtMiso = '0;
        if (fRdOwner == OwnCpu) begin
            ABus.ACpuMiso = ABus.AMemMiso;
        end
        if (fExtAck && (fRdOwner == OwnExt)) begin
            ABus.AExtMiso = ABus.AMemMiso;
        end
    end

    // Status outputs.
    always_comb begin
        ABus.AExtAck      = fExtAck;
        ABus.AConflictCnt = fConflictCnt;
        ABus.ADbgPrio     = fPrio;
        ABus.ADbgRdOwner  = fRdOwner;
    end

endmodule

// File: tb/tb_mi_ram_arb.sv
// Directed bench for mi_ram_arb.
// A behavioural RAM model has 1-cycle read latency, honours byte enables and
// updates only on enabled edges. Expected read data is queued when a read is
// granted and popped when the data should appear. The small counter width
// makes counter saturation reachable in a short run.
module tb_mi_ram_arb;

    localparam int CW = 4;

    logic clk;
    logic rst;
    logic clkEn;

    int vectors    = 0;
    int miscompares = 0;

    logic [63:0] exp_q[$];
    logic [63:0] ram[logic [28:0]];
    logic [63:0] expData;
    logic [63:0] cpuPrev;
    int          expCnt;
    int          g;

    mi_ram_arb_if #(.CCntW(CW)) bus ();

    mi_ram_arb #(.CCpuFirst(1'b1), .CCntW(CW)) dut (
        .AClkH   (clk),
        .AResetH (rst),
        .AClkHEn (clkEn),
        .ABus    (bus)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: read-before-write, byte-enabled write, enabled edges only.
    initial bus.AMemMiso = 64'h0;
    always @(posedge clk) begin : ram_model
        logic [63:0] w;
        if (clkEn) begin
            if (bus.AMemRdEn != 8'h00)
                bus.AMemMiso <= ram.exists(bus.AMemAddr) ? ram[bus.AMemAddr] : 64'h0;
            if (bus.AMemWrEn != 8'h00) begin
                w = ram.exists(bus.AMemAddr) ? ram[bus.AMemAddr] : 64'h0;
                for (int b = 0; b < 8; b++)
                    if (bus.AMemWrEn[b]) w[b*8 +: 8] = bus.AMemMosi[b*8 +: 8];
                ram[bus.AMemAddr] = w;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic clear_reqs();
        bus.ACpuAddr = '0; bus.ACpuMosi = '0; bus.ACpuWrEn = '0; bus.ACpuRdEn = '0;
        bus.AExtReq  = 1'b0; bus.AExtAddr = '0; bus.AExtMosi = '0;
        bus.AExtWrEn = '0; bus.AExtRdEn = '0;
    endtask

    function automatic logic [63:0] ram_rd(input logic [28:0] a);
        return ram.exists(a) ? ram[a] : 64'h0;
    endfunction

    initial begin
        rst = 1'b1;
        clkEn = 1'b1;
        bus.AExecEnI = 1'b1;
        clear_reqs();
        ram[29'h100] = 64'h1122334455667788;
        ram[29'h028] = 64'hA5A5_0F0F_C3C3_9696;
        ram[29'h030] = 64'h0123_4567_89AB_CDEF;

        // Reset state, no requests
        repeat (2) @(negedge clk);
        #1;
        chk("rst_memwren", 64'(bus.AMemWrEn), 64'h0);
        chk("rst_memrden", 64'(bus.AMemRdEn), 64'h0);
        chk("rst_memaddr", 64'(bus.AMemAddr), 64'h0);
        chk("rst_extack", 64'(bus.AExtAck), 64'h0);
        chk("rst_cnt", 64'(bus.AConflictCnt), 64'h0);
        chk("rst_cpumiso", bus.ACpuMiso, 64'h0);
        chk("rst_extmiso", bus.AExtMiso, 64'h0);
        chk("rst_exec_hi", 64'(bus.AExecEnO), 64'h1);
        bus.AExecEnI = 1'b0;
        #1 chk("rst_exec_lo", 64'(bus.AExecEnO), 64'h0);
        bus.AExecEnI = 1'b1;
        @(negedge clk) rst = 1'b0;

        // Cpu read only
        @(negedge clk);
        bus.ACpuAddr = 29'h100; bus.ACpuRdEn = 8'hFF;
        #1;
        chk("cpurd_memrden", 64'(bus.AMemRdEn), 64'hFF);
        chk("cpurd_memaddr", 64'(bus.AMemAddr), 64'h100);
        chk("cpurd_exec", 64'(bus.AExecEnO), 64'h1);
        chk("cpurd_miso_early", bus.ACpuMiso, 64'h0);
        exp_q.push_back(64'h1122334455667788);
        @(negedge clk);
        bus.ACpuRdEn = 8'h00;
        #1;
        chk("cpurd_miso", bus.ACpuMiso, exp_q.pop_front());
        chk("cpurd_exec2", 64'(bus.AExecEnO), 64'h1);
        @(negedge clk);
        #1 chk("cpurd_miso_after", bus.ACpuMiso, 64'h0);

        // Ext write only, request held through the ack
        @(negedge clk);
        bus.AExtReq = 1'b1; bus.AExtAddr = 29'h20;
        bus.AExtMosi = 64'hDEADBEEF; bus.AExtWrEn = 8'h0F;
        #1;
        chk("extwr_memwren", 64'(bus.AMemWrEn), 64'h0F);
        chk("extwr_memaddr", 64'(bus.AMemAddr), 64'h20);
        chk("extwr_memmosi", bus.AMemMosi, 64'hDEADBEEF);
        chk("extwr_ack_n", 64'(bus.AExtAck), 64'h0);
        @(negedge clk);
        #1;
        chk("extwr_ack_n1", 64'(bus.AExtAck), 64'h1);
        chk("extwr_no_second", 64'(bus.AMemWrEn), 64'h0);
        bus.AExtReq = 1'b0; bus.AExtWrEn = 8'h00;
        @(negedge clk);
        #1;
        chk("extwr_ack_n2", 64'(bus.AExtAck), 64'h0);
        chk("extwr_ram", ram_rd(29'h20), 64'h00000000DEADBEEF);
        chk("conf_prio0", 64'(bus.ADbgPrio), 64'h1);

        // Both request continuously: C, E, C(ack), C, E, C(ack), ...
        expCnt = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (i == 0) begin
                bus.ACpuAddr = 29'h100; bus.ACpuRdEn = 8'hFF;
                bus.AExtReq = 1'b1; bus.AExtAddr = 29'h28; bus.AExtRdEn = 8'hFF;
            end
            #1;
            g = i % 3;
            cpuPrev = (i > 0 && ((i - 1) % 3) != 1) ? 64'h1122334455667788 : 64'h0;
            chk($sformatf("conf_exec[%0d]", i), 64'(bus.AExecEnO), 64'(g != 1));
            chk($sformatf("conf_addr[%0d]", i), 64'(bus.AMemAddr), (g == 1) ? 64'h28 : 64'h100);
            chk($sformatf("conf_ack[%0d]", i), 64'(bus.AExtAck), 64'(g == 2));
            if (g == 2) chk($sformatf("conf_extmiso[%0d]", i), bus.AExtMiso, exp_q.pop_front());
            else        chk($sformatf("conf_extmiso[%0d]", i), bus.AExtMiso, 64'h0);
            chk($sformatf("conf_cpumiso[%0d]", i), bus.ACpuMiso, cpuPrev);
            chk($sformatf("conf_cnt[%0d]", i), 64'(bus.AConflictCnt), 64'(expCnt));
            if (g != 2 && expCnt != 15) expCnt++;
            if (g == 1) exp_q.push_back(ram_rd(29'h28));
        end
        @(negedge clk);
        clear_reqs();
        #1;
        chk("conf_cnt_sat", 64'(bus.AConflictCnt), 64'd15);
        chk("conf_prio_end", 64'(bus.ADbgPrio), 64'h1);
        chk("conf_cpumiso_end", bus.ACpuMiso, 64'h1122334455667788);
        chk("conf_ack_end", 64'(bus.AExtAck), 64'h0);

        // Clock enable low around an Ext read
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 0) begin
                clkEn = 1'b0;
                bus.AExtReq = 1'b1; bus.AExtAddr = 29'h30; bus.AExtRdEn = 8'hFF;
            end
            #1;
            chk($sformatf("en0_pre_memrden[%0d]", k), 64'(bus.AMemRdEn), 64'hFF);
            chk($sformatf("en0_pre_ack[%0d]", k), 64'(bus.AExtAck), 64'h0);
            chk($sformatf("en0_pre_owner[%0d]", k), 64'(bus.ADbgRdOwner), 64'h0);
        end
        @(negedge clk);
        clkEn = 1'b1;
        #1 chk("en1_grant_ack", 64'(bus.AExtAck), 64'h0);
        exp_q.push_back(ram_rd(29'h30));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 0) clkEn = 1'b0;
            #1;
            expData = exp_q[0];
            chk($sformatf("en0_ack[%0d]", k), 64'(bus.AExtAck), 64'h1);
            chk($sformatf("en0_extmiso[%0d]", k), bus.AExtMiso, expData);
            chk($sformatf("en0_owner[%0d]", k), 64'(bus.ADbgRdOwner), 64'h2);
            chk($sformatf("en0_prio[%0d]", k), 64'(bus.ADbgPrio), 64'h1);
        end
        @(negedge clk);
        clkEn = 1'b1;
        #1;
        chk("en1_ack", 64'(bus.AExtAck), 64'h1);
        chk("en1_extmiso", bus.AExtMiso, exp_q.pop_front());
        chk("en1_memrden", 64'(bus.AMemRdEn), 64'h0);
        @(negedge clk);
        clear_reqs();
        #1;
        chk("en1_ack_off", 64'(bus.AExtAck), 64'h0);
        chk("en1_extmiso_off", bus.AExtMiso, 64'h0);
        chk("en1_owner_off", 64'(bus.ADbgRdOwner), 64'h0);

        // Reset in the cycle after an Ext grant
        @(negedge clk);
        bus.ACpuAddr = 29'h40; bus.ACpuMosi = 64'hCAFE_F00D_1234_5678; bus.ACpuWrEn = 8'hFF;
        bus.AExtReq = 1'b1; bus.AExtAddr = 29'h48;
        bus.AExtMosi = 64'h0BAD_C0DE_5555_AAAA; bus.AExtWrEn = 8'hFF;
        #1;
        chk("rstx_cpu_wins", 64'(bus.AMemAddr), 64'h40);
        chk("rstx_exec", 64'(bus.AExecEnO), 64'h1);
        chk("rstx_cnt_held", 64'(bus.AConflictCnt), 64'd15);
        @(negedge clk);
        bus.ACpuWrEn = 8'h00;
        #1;
        chk("rstx_ext_grant", 64'(bus.AMemAddr), 64'h48);
        chk("rstx_prio_moved", 64'(bus.ADbgPrio), 64'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstx_no_ack", 64'(bus.AExtAck), 64'h0);
        chk("rstx_prio_reset", 64'(bus.ADbgPrio), 64'h1);
        chk("rstx_cnt_reset", 64'(bus.AConflictCnt), 64'h0);
        chk("rstx_owner_reset", 64'(bus.ADbgRdOwner), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstx_reissue_addr", 64'(bus.AMemAddr), 64'h48);
        chk("rstx_reissue_wren", 64'(bus.AMemWrEn), 64'hFF);
        chk("rstx_reissue_noack", 64'(bus.AExtAck), 64'h0);
        @(negedge clk);
        #1;
        chk("rstx_ack", 64'(bus.AExtAck), 64'h1);
        chk("rstx_ack_nowr", 64'(bus.AMemWrEn), 64'h0);
        clear_reqs();
        @(negedge clk);
        #1;
        chk("rstx_ack_off", 64'(bus.AExtAck), 64'h0);
        chk("rstx_ram_cpu", ram_rd(29'h40), 64'hCAFE_F00D_1234_5678);
        chk("rstx_ram_ext", ram_rd(29'h48), 64'h0BAD_C0DE_5555_AAAA);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
